// File: rtl/rtc_access_sched.sv
// rtc_access_sched: arbitrates RTC register read sweeps and single writes onto a handshake bus
module rtc_access_sched #(
  parameter logic [7:0] READ_BASE  = 8'h21,
  parameter int         READ_COUNT = 4,
  parameter int         TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       tick_read,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       bus_ack,
  input  logic [7:0] bus_rdata,
  output logic       bus_req,
  output logic       bus_rw,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic [7:0] date,
  output logic       rd_valid,
  output logic       wr_busy,
  output logic       wr_done,
  output logic       err,
  output logic       wr_drop
);
  localparam int IW = (READ_COUNT > 1) ? $clog2(READ_COUNT) : 1;
  localparam logic [IW-1:0] LAST = IW'(READ_COUNT - 1);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, GAP} state_t;
  state_t state, nxt, idle_nxt;
  logic wr_pend, rd_pend, sweep_act, in_wait, done, tout, launch;
  logic [IW-1:0] idx;
  logic [7:0] tcnt, wa, wd, off;
  logic [7:0] sh [READ_COUNT];
  always_comb begin
    in_wait  = state == RD_WAIT || state == WR_WAIT;
    tout     = in_wait && !bus_ack && tcnt == 8'(TIMEOUT);
    done     = in_wait && (bus_ack || tout);
    idle_nxt = wr_pend ? WR_WAIT : rd_pend ? RD_WAIT : IDLE;
    nxt      = state == IDLE ? idle_nxt :
               in_wait ? (done ? GAP : state) :
               wr_pend ? WR_WAIT : sweep_act ? RD_WAIT : idle_nxt;
    launch   = nxt == RD_WAIT && !sweep_act;
    off      = wa - READ_BASE;
  end
  assign bus_req   = in_wait;
  assign bus_rw    = state == RD_WAIT;
  assign bus_addr  = state == RD_WAIT ? READ_BASE + 8'(idx) : state == WR_WAIT ? wa : '0;
  assign bus_wdata = state == WR_WAIT ? wd : '0;
  assign segundos  = sh[0];
  assign minutos   = sh[1];
  assign horas     = sh[2];
  assign date      = sh[3];
  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= IDLE;
      wr_pend   <= 1'b0;
      wr_busy   <= 1'b0;
      rd_pend   <= 1'b0;
      sweep_act <= 1'b0;
      idx       <= '0;
      tcnt      <= '0;
      wa        <= '0;
      wd        <= '0;
      rd_valid  <= 1'b0;
      wr_done   <= 1'b0;
      err       <= 1'b0;
      wr_drop   <= 1'b0;
      for (int i = 0; i < READ_COUNT; i++) sh[i] <= '0;
    end else begin
      state    <= nxt;
      tcnt     <= nxt == state ? tcnt + 8'd1 : '0;
      wr_drop  <= wr_req && wr_busy;
      err      <= tout;
      wr_done  <= state == WR_WAIT && done;
      rd_valid <= state == RD_WAIT && bus_ack && idx == LAST;
      rd_pend  <= tick_read || (rd_pend && !launch);
      if (wr_req && !wr_busy) begin
        wr_pend <= 1'b1;
        wr_busy <= 1'b1;
        wa      <= wr_addr;
        wd      <= wr_data;
      end else if (state == WR_WAIT && done) begin
        wr_pend <= 1'b0;
        wr_busy <= 1'b0;
      end
      // a successful write into the swept window keeps the shadow coherent
      if (state == WR_WAIT && bus_ack && off < 8'(READ_COUNT)) sh[off[IW-1:0]] <= wd;
      if (launch) begin
        sweep_act <= 1'b1;
        idx       <= '0;
      end else if (state == RD_WAIT && done) begin
        if (bus_ack) sh[idx] <= bus_rdata;
        if (!bus_ack || idx == LAST) sweep_act <= 1'b0;
        else idx <= idx + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_rtc_access_sched.sv
// tb_rtc_access_sched: directed checks of sweep, write preemption, drop, timeout and reset
module tb_rtc_access_sched;
  logic clk = 0, Reset = 1, tick_read = 0, wr_req = 0, bus_ack = 0;
  logic [7:0] wr_addr = 0, wr_data = 0, bus_rdata = 0;
  logic bus_req, bus_rw, rd_valid, wr_busy, wr_done, err, wr_drop;
  logic [7:0] bus_addr, bus_wdata, segundos, minutos, horas, date;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  rtc_access_sched dut (
    .clk(clk), .Reset(Reset), .tick_read(tick_read), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .segundos(segundos), .minutos(minutos), .horas(horas), .date(date),
    .rd_valid(rd_valid), .wr_busy(wr_busy), .wr_done(wr_done), .err(err), .wr_drop(wr_drop)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_req();
    int n = 0;
    while (!bus_req && n < 50) begin
      step();
      n++;
    end
    chk("req_seen", 32'(bus_req), 1);
  endtask
  task automatic serve(input logic rw, input logic [7:0] addr, input logic [7:0] wd,
                       input logic [7:0] rd, input int dly);
    wait_req();
    chk("bus_rw", 32'(bus_rw), 32'(rw));
    chk("bus_addr", 32'(bus_addr), 32'(addr));
    if (!rw) chk("bus_wdata", 32'(bus_wdata), 32'(wd));
    repeat (dly) step();
    bus_ack = 1;
    bus_rdata = rd;
    step();
    bus_ack = 0;
    chk("gap", 32'(bus_req), 0);
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_req = 1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_req = 0;
  endtask
  task automatic tick();
    tick_read = 1;
    step();
    tick_read = 0;
  endtask
  task automatic sweep(input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      serve(1'b1, 8'h21 + 8'(i), 8'h00, v[8*(3-i) +: 8], 3);
      if (i < 3) chk("rd_valid_early", 32'(rd_valid), 0);
    end
    chk("rd_valid", 32'(rd_valid), 1);
    step();
    chk("rd_valid_pulse", 32'(rd_valid), 0);
  endtask
  initial begin
    int n, seen;
    repeat (3) step();
    Reset = 0;
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_sec", 32'(segundos), 0);
    chk("rst_busy", 32'(wr_busy), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    repeat (5) step();
    chk("idle_noreq", 32'(bus_req), 0);
    // plain four-register sweep
    tick();
    sweep(32'h12345678);
    chk("sec", 32'(segundos), 32'h12);
    chk("min", 32'(minutos), 32'h34);
    chk("hor", 32'(horas), 32'h56);
    chk("date", 32'(date), 32'h78);
    // write preempts the sweep between transfers and the sweep resumes
    tick();
    wait_req();
    chk("pre_addr", 32'(bus_addr), 32'h21);
    wr(8'h22, 8'h59);
    chk("pre_busy", 32'(wr_busy), 1);
    serve(1'b1, 8'h21, 8'h00, 8'hA1, 3);
    serve(1'b0, 8'h22, 8'h59, 8'h00, 2);
    chk("min_wr", 32'(minutos), 32'h59);
    chk("pre_done", 32'(wr_done), 1);
    chk("pre_busy_clr", 32'(wr_busy), 0);
    serve(1'b1, 8'h22, 8'h00, 8'hB2, 1);
    chk("min_rd", 32'(minutos), 32'hB2);
    serve(1'b1, 8'h23, 8'h00, 8'hC3, 1);
    serve(1'b1, 8'h24, 8'h00, 8'hD4, 1);
    chk("pre_valid", 32'(rd_valid), 1);
    chk("pre_sec", 32'(segundos), 32'hA1);
    repeat (2) step();
    // second write while busy is dropped
    wr(8'h30, 8'hAA);
    step();
    wr(8'h31, 8'hBB);
    chk("drop", 32'(wr_drop), 1);
    serve(1'b0, 8'h30, 8'hAA, 8'h00, 1);
    chk("drop_done", 32'(wr_done), 1);
    seen = 0;
    repeat (10) begin
      step();
      if (bus_req) seen++;
    end
    chk("no_second_wr", 32'(seen), 0);
    // write timeout
    wr(8'h40, 8'hCC);
    wait_req();
    n = 0;
    while (!err && n < 400) begin
      step();
      n++;
    end
    chk("to_err", 32'(err), 1);
    chk("to_len", 32'(n >= 255), 1);
    chk("to_done", 32'(wr_done), 1);
    chk("to_req", 32'(bus_req), 0);
    chk("to_busy", 32'(wr_busy), 0);
    step();
    chk("to_err_pulse", 32'(err), 0);
    // late ack just inside the limit still succeeds
    wr(8'h41, 8'hDD);
    wait_req();
    repeat (254) step();
    bus_ack = 1;
    step();
    bus_ack = 0;
    chk("late_err", 32'(err), 0);
    chk("late_done", 32'(wr_done), 1);
    chk("late_req", 32'(bus_req), 0);
    repeat (2) step();
    // simultaneous write and tick: write first, then full sweep
    tick_read = 1;
    wr_req = 1;
    wr_addr = 8'h50;
    wr_data = 8'h11;
    step();
    tick_read = 0;
    wr_req = 0;
    chk("wr_lat0", 32'(bus_req), 0);
    step();
    chk("wr_lat1", 32'(bus_req), 1);
    serve(1'b0, 8'h50, 8'h11, 8'h00, 1);
    sweep(32'h01020304);
    chk("both_sec", 32'(segundos), 32'h01);
    chk("both_date", 32'(date), 32'h04);
    // stray ack while idle
    bus_ack = 1;
    bus_rdata = 8'hFF;
    step();
    bus_ack = 0;
    chk("stray_sec", 32'(segundos), 32'h01);
    chk("stray_req", 32'(bus_req), 0);
    // reset in the middle of a read
    tick();
    wait_req();
    Reset = 1;
    step();
    Reset = 0;
    chk("mid_rst_req", 32'(bus_req), 0);
    chk("mid_rst_sec", 32'(segundos), 0);
    chk("mid_rst_date", 32'(date), 0);
    seen = 0;
    repeat (10) begin
      step();
      if (bus_req) seen++;
    end
    chk("post_rst_idle", 32'(seen), 0);
    tick();
    sweep(32'h9ABCDEF0);
    chk("final_hor", 32'(horas), 32'hDE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
